display_scan_ctrl: RTL and testbench

DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

---
 rtl/display_scan_if.sv | 21 ++
 rtl/display_scan_ctrl.sv | 158 +++++++++++++++
 tb/tb_display_scan_ctrl.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/display_scan_if.sv
// Producer-side handshake into the display scan controller.
// A word moves on every rising clk edge where in_valid && in_ready. in_valid and
// in_value must stay stable while in_valid is high and in_ready is low. in_ready
// comes straight from a register and never depends on in_valid.
interface display_scan_if;
  logic        in_valid;
  logic [15:0] in_value;
  logic        in_ready;

  modport master (
    output in_valid,
    output in_value,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_value,
    output in_ready
  );
endinterface

// File: rtl/display_scan_ctrl.sv
// Four-digit multiplexed BCD display scanner with a one-deep pending register.
// New values reach the display only at frame boundaries, so a frame never mixes old and new digits.
module display_scan_ctrl #(
  parameter int SCAN_DIV = 50000,
  parameter int DEAD     = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  display_scan_if.slave  in_bus,
  output logic [3:0]     digit_bcd,
  output logic [3:0]     digit_an,
  output logic           frame_done,
  output logic           bad_digit,
  output logic [1:0]     dbg_state
);

  localparam int            CW       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_DEAD = CW'(DEAD);

  typedef enum logic [1:0] {
    SLOT0 = 2'd0,
    SLOT1 = 2'd1,
    SLOT2 = 2'd2,
    SLOT3 = 2'd3
  } slot_t;

  slot_t         slot_q;
  slot_t         slot_d;
  logic [CW-1:0] div_cnt;
  logic          tick;
  logic          frame_bnd;
  logic          xfer;
  logic          pend_full;
  logic [15:0]   pend_val;
  logic [15:0]   disp_val;
  logic [1:0]    digit_sel;

  logic [3:0]    sel_nib;
  logic [3:0]    lead_zero;
  logic [3:0]    an_d;
  logic [3:0]    bcd_d;
  logic          in_bad;

  assign tick      = (div_cnt == CNT_LAST);
  assign digit_sel = slot_q;
  assign frame_bnd = tick && (slot_q == SLOT3);
  // pend_full blocks in_ready, so a transfer can never collide with a boundary load
  assign xfer      = in_bus.in_valid && !pend_full;
  assign in_bus.in_ready = !pend_full;
  assign dbg_state = slot_q;

  // Digit slot FSM: one state per anode, advancing on each divider tick.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot_q <= SLOT0;
    end else begin
      slot_q <= slot_d;
    end
  end

  always_comb begin
    slot_d = slot_q;
    if (tick) begin
      case (slot_q)
        SLOT0:   slot_d = SLOT1;
        SLOT1:   slot_d = SLOT2;
        SLOT2:   slot_d = SLOT3;
        SLOT3:   slot_d = SLOT0;
        default: slot_d = SLOT0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + CW'(1);
    end
  end

  always_comb begin
    in_bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (in_bus.in_value[i*4 +: 4] > 4'd9) begin
        in_bad = 1'b1;
      end
    end
  end

  // Pending and display registers: display only ever loads at a frame boundary.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_full <= 1'b0;
      pend_val  <= 16'h0000;
      disp_val  <= 16'h0000;
      bad_digit <= 1'b0;
    end else begin
      if (frame_bnd && pend_full) begin
        disp_val  <= pend_val;
        pend_full <= 1'b0;
      end else if (xfer) begin
        pend_val  <= in_bus.in_value;
        pend_full <= 1'b1;
      end
      if (xfer && in_bad) begin
        bad_digit <= 1'b1;
      end
    end
  end

  // lead_zero[n]: digit n and every digit above it are zero; digit0 is never blanked.
  always_comb begin
    lead_zero    = 4'b0000;
    lead_zero[3] = (disp_val[15:12] == 4'd0);
    lead_zero[2] = lead_zero[3] && (disp_val[11:8] == 4'd0);
    lead_zero[1] = lead_zero[2] && (disp_val[7:4] == 4'd0);
    lead_zero[0] = 1'b0;
  end

  always_comb begin
    sel_nib = 4'h0;
    case (digit_sel)
      2'd0:    sel_nib = disp_val[3:0];
      2'd1:    sel_nib = disp_val[7:4];
      2'd2:    sel_nib = disp_val[11:8];
      2'd3:    sel_nib = disp_val[15:12];
      default: sel_nib = 4'h0;
    endcase
  end

  always_comb begin
    an_d  = 4'b1111;
    bcd_d = 4'hF;
    if (div_cnt >= CNT_DEAD) begin
      an_d = ~(4'b0001 << digit_sel);
      if (!lead_zero[digit_sel] && (sel_nib <= 4'd9)) begin
        bcd_d = sel_nib;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      digit_an   <= 4'b1111;
      digit_bcd  <= 4'hF;
      frame_done <= 1'b0;
    end else begin
      digit_an   <= an_d;
      digit_bcd  <= bcd_d;
      frame_done <= frame_bnd;
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl at SCAN_DIV=8, DEAD=2 (32-cycle frames).
module tb_display_scan_ctrl;

  logic       clk;
  logic       rst_n;
  logic [3:0] digit_bcd;
  logic [3:0] digit_an;
  logic       frame_done;
  logic       bad_digit;
  logic [1:0] dbg_state;

  display_scan_if bus ();

  display_scan_ctrl #(.SCAN_DIV(8), .DEAD(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_bus     (bus),
    .digit_bcd  (digit_bcd),
    .digit_an   (digit_an),
    .frame_done (frame_done),
    .bad_digit  (bad_digit),
    .dbg_state  (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: k counts edges since reset release.
  int          k = 0;
  logic [15:0] m_disp = 16'h0000;
  logic [15:0] m_pend = 16'h0000;
  logic        m_full = 1'b0;
  logic        m_bad  = 1'b0;
  logic        last_xfer = 1'b0;
  logic [3:0]  exp_an  = 4'hF;
  logic [3:0]  exp_bcd = 4'hF;
  logic        exp_fd  = 1'b0;

  function automatic logic [3:0] model_nib(input logic [15:0] d, input int s);
    int top;
    logic [3:0] n;
    top = 0;
    for (int i = 0; i < 4; i++) if (d[i*4 +: 4] != 4'd0) top = i;
    n = d[s*4 +: 4];
    if (s > top) return 4'hF;
    if (n > 4'd9) return 4'hF;
    return n;
  endfunction

  function automatic logic nib_bad(input logic [15:0] v);
    for (int i = 0; i < 4; i++) if (v[i*4 +: 4] > 4'd9) return 1'b1;
    return 1'b0;
  endfunction

  // Advance one clock and update the reference, then settle 1 time unit past the edge.
  task automatic step();
    int c;
    int s;
    c = k % 8;
    s = (k / 8) % 4;
    @(posedge clk);
    last_xfer = 1'b0;
    if (!rst_n) begin
      k = 0; m_disp = 16'h0000; m_full = 1'b0; m_bad = 1'b0;
      exp_an = 4'hF; exp_bcd = 4'hF; exp_fd = 1'b0;
    end else begin
      exp_an  = (c < 2) ? 4'hF : ~(4'b0001 << s);
      exp_bcd = (c < 2) ? 4'hF : model_nib(m_disp, s);
      exp_fd  = (c == 7) && (s == 3);
      if (exp_fd && m_full) begin
        m_disp = m_pend;
        m_full = 1'b0;
      end else if (bus.in_valid && !m_full) begin
        m_pend = bus.in_value;
        m_full = 1'b1;
        last_xfer = 1'b1;
        if (nib_bad(bus.in_value)) m_bad = 1'b1;
      end
      k++;
    end
    #1;
  endtask

  task automatic align_mid_frame();
    for (int i = 0; i < 40 && (k % 32) != 10; i++) step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_value = 16'h0000;
    repeat (3) step();
    n_checks++;
    if ({digit_an, digit_bcd, frame_done, bus.in_ready, bad_digit} !== {4'b1111, 4'hF, 1'b0, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_values: an/bcd/fd/rdy/bad got %b %h %b %b %b want 1111 f 0 1 0",
               digit_an, digit_bcd, frame_done, bus.in_ready, bad_digit);
    end
    n_checks++;
    if (dbg_state !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_state: got %0d want 0", dbg_state);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_idle();
    int fd_cnt;
    fd_cnt = 0;
    for (int i = 0; i < 64; i++) begin
      step();
      n_checks++;
      if ({digit_an, digit_bcd, frame_done, bus.in_ready, bad_digit} !== {exp_an, exp_bcd, exp_fd, !m_full, m_bad}) begin
        n_fail++;
        $display("FAIL idle_cycle k=%0d: got %b %h %b %b %b want %b %h %b %b %b", k, digit_an, digit_bcd,
                 frame_done, bus.in_ready, bad_digit, exp_an, exp_bcd, exp_fd, !m_full, m_bad);
      end
      if (frame_done) fd_cnt++;
      if (k == 5) begin
        n_checks++;
        if ({digit_an, digit_bcd} !== {4'b1110, 4'h0}) begin
          n_fail++;
          $display("FAIL idle_slot0: got %b %h want 1110 0", digit_an, digit_bcd);
        end
      end
      if (k == 13) begin
        n_checks++;
        if ({digit_an, digit_bcd} !== {4'b1101, 4'hF}) begin
          n_fail++;
          $display("FAIL idle_slot1_blank: got %b %h want 1101 f", digit_an, digit_bcd);
        end
      end
      if (k == 7 || k == 8) begin
        n_checks++;
        if (dbg_state !== ((k == 8) ? 2'd1 : 2'd0)) begin
          n_fail++;
          $display("FAIL first_tick k=%0d: slot got %0d", k, dbg_state);
        end
      end
    end
    n_checks++;
    if (fd_cnt != 2) begin
      n_fail++;
      $display("FAIL idle_frame_count: got %0d want 2", fd_cnt);
    end
  endtask

  task automatic test_accept();
    logic [3:0] bcd_tab [4];
    logic [3:0] an_tab [4];
    logic       seen;
    bcd_tab[0] = 4'h4; bcd_tab[1] = 4'h3; bcd_tab[2] = 4'h2; bcd_tab[3] = 4'h1;
    an_tab[0] = 4'b1110; an_tab[1] = 4'b1101; an_tab[2] = 4'b1011; an_tab[3] = 4'b0111;
    align_mid_frame();
    bus.in_valid = 1'b1;
    bus.in_value = 16'h1234;
    step();
    bus.in_valid = 1'b0;
    n_checks++;
    if (bus.in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL accept_ready_low: got %b want 0", bus.in_ready);
    end
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      step();
      if (frame_done) begin
        seen = 1'b1;
        n_checks++;
        if (bus.in_ready !== 1'b1) begin
          n_fail++;
          $display("FAIL accept_ready_at_boundary: got %b want 1", bus.in_ready);
        end
      end
    end
    if (!seen) begin
      n_checks++; n_fail++;
      $display("FAIL accept_boundary_timeout: frame_done got 0 want 1");
    end
    for (int i = 0; i < 32; i++) begin
      step();
      n_checks++;
      if ({digit_an, digit_bcd, frame_done, bus.in_ready} !== {exp_an, exp_bcd, exp_fd, !m_full}) begin
        n_fail++;
        $display("FAIL accept_cycle k=%0d: got %b %h %b %b want %b %h %b %b", k, digit_an, digit_bcd,
                 frame_done, bus.in_ready, exp_an, exp_bcd, exp_fd, !m_full);
      end
      if (k % 8 == 5) begin
        n_checks++;
        if ({digit_an, digit_bcd} !== {an_tab[((k-1)/8)%4], bcd_tab[((k-1)/8)%4]}) begin
          n_fail++;
          $display("FAIL accept_digit slot%0d: got %b %h want %b %h", ((k-1)/8)%4, digit_an, digit_bcd,
                   an_tab[((k-1)/8)%4], bcd_tab[((k-1)/8)%4]);
        end
      end
    end
  endtask

  task automatic test_pending_full();
    logic [3:0] f1 [4];
    logic [3:0] f2 [4];
    logic       seen;
    f1[0] = 4'h0; f1[1] = 4'h5; f1[2] = 4'hF; f1[3] = 4'hF;
    f2[0] = 4'h9; f2[1] = 4'h9; f2[2] = 4'h9; f2[3] = 4'hF;
    align_mid_frame();
    bus.in_valid = 1'b1;
    bus.in_value = 16'h0050;
    step();
    bus.in_value = 16'h0999;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      step();
      seen = frame_done;
      n_checks++;
      if (bus.in_ready !== frame_done) begin
        n_fail++;
        $display("FAIL pend_ready k=%0d: got %b want %b", k, bus.in_ready, frame_done);
      end
    end
    if (!seen) begin
      n_checks++; n_fail++;
      $display("FAIL pend_boundary_timeout: frame_done got 0 want 1");
    end
    step();
    bus.in_valid = 1'b0;
    n_checks++;
    if (bus.in_ready !== 1'b0 || !last_xfer) begin
      n_fail++;
      $display("FAIL pend_second_accept: ready got %b want 0", bus.in_ready);
    end
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 32; i++) begin
        step();
        n_checks++;
        if ({digit_an, digit_bcd, frame_done} !== {exp_an, exp_bcd, exp_fd}) begin
          n_fail++;
          $display("FAIL pend_cycle k=%0d: got %b %h %b want %b %h %b", k, digit_an, digit_bcd, frame_done,
                   exp_an, exp_bcd, exp_fd);
        end
        if (k % 8 == 5) begin
          n_checks++;
          if (digit_bcd !== ((f == 0) ? f1[((k-1)/8)%4] : f2[((k-1)/8)%4])) begin
            n_fail++;
            $display("FAIL pend_digit frame%0d slot%0d: got %h want %h", f, ((k-1)/8)%4, digit_bcd,
                     (f == 0) ? f1[((k-1)/8)%4] : f2[((k-1)/8)%4]);
          end
        end
        if (k % 32 == 0) break;
      end
    end
  endtask

  task automatic test_bad_digit();
    logic [3:0] bcd_tab [4];
    logic       seen;
    bcd_tab[0] = 4'h4; bcd_tab[1] = 4'hF; bcd_tab[2] = 4'h2; bcd_tab[3] = 4'h1;
    align_mid_frame();
    n_checks++;
    if (bad_digit !== 1'b0) begin
      n_fail++;
      $display("FAIL bad_before: got %b want 0", bad_digit);
    end
    bus.in_valid = 1'b1;
    bus.in_value = 16'h12A4;
    step();
    bus.in_valid = 1'b0;
    n_checks++;
    if (bad_digit !== 1'b1) begin
      n_fail++;
      $display("FAIL bad_set: got %b want 1", bad_digit);
    end
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      step();
      seen = frame_done;
    end
    if (!seen) begin
      n_checks++; n_fail++;
      $display("FAIL bad_boundary_timeout: frame_done got 0 want 1");
    end
    for (int i = 0; i < 32; i++) begin
      step();
      if (k % 8 == 5) begin
        n_checks++;
        if ({digit_an, digit_bcd} !== {exp_an, bcd_tab[((k-1)/8)%4]}) begin
          n_fail++;
          $display("FAIL bad_digit_show slot%0d: got %b %h want %b %h", ((k-1)/8)%4, digit_an, digit_bcd,
                   exp_an, bcd_tab[((k-1)/8)%4]);
        end
      end
    end
    n_checks++;
    if (bad_digit !== 1'b1) begin
      n_fail++;
      $display("FAIL bad_sticky: got %b want 1", bad_digit);
    end
  endtask

  task automatic test_reset_mid();
    int fd_cnt;
    align_mid_frame();
    bus.in_valid = 1'b1;
    bus.in_value = 16'h5678;
    step();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 32 && ((k / 8) % 4) != 2; i++) step();
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    n_checks++;
    if ({digit_an, digit_bcd, frame_done, bus.in_ready, bad_digit, dbg_state} !==
        {4'b1111, 4'hF, 1'b0, 1'b1, 1'b0, 2'd0}) begin
      n_fail++;
      $display("FAIL midreset_values: got %b %h %b %b %b %0d want 1111 f 0 1 0 0", digit_an, digit_bcd,
               frame_done, bus.in_ready, bad_digit, dbg_state);
    end
    fd_cnt = 0;
    for (int i = 0; i < 64; i++) begin
      step();
      if (frame_done) fd_cnt++;
      n_checks++;
      if ((digit_bcd >= 4'h5 && digit_bcd <= 4'h8) || (frame_done && k != 32 && k != 64)) begin
        n_fail++;
        $display("FAIL midreset_leak k=%0d: bcd got %h fd got %b", k, digit_bcd, frame_done);
      end
      if (k == 5) begin
        n_checks++;
        if ({digit_an, digit_bcd} !== {4'b1110, 4'h0}) begin
          n_fail++;
          $display("FAIL midreset_zero: got %b %h want 1110 0", digit_an, digit_bcd);
        end
      end
    end
    n_checks++;
    if (fd_cnt != 2) begin
      n_fail++;
      $display("FAIL midreset_frames: got %0d want 2", fd_cnt);
    end
  endtask

  task automatic test_back_to_back();
    int         frames;
    int         dut_xfer;
    logic [3:0] val;
    for (int i = 0; i < 32 && (k % 32) != 0; i++) step();
    frames = 0;
    dut_xfer = 0;
    val = 4'd1;
    bus.in_valid = 1'b1;
    bus.in_value = {12'h000, val};
    for (int i = 0; i < 192; i++) begin
      if (bus.in_ready) dut_xfer++;
      step();
      if (last_xfer) begin
        val = val + 4'd1;
        bus.in_value = {12'h000, val};
      end
      if (frame_done) frames++;
      n_checks++;
      if ($countones(~digit_an) > 1 || {digit_an, digit_bcd, frame_done} !== {exp_an, exp_bcd, exp_fd}) begin
        n_fail++;
        $display("FAIL b2b_cycle k=%0d: got %b %h %b want %b %h %b", k, digit_an, digit_bcd, frame_done,
                 exp_an, exp_bcd, exp_fd);
      end
      if (k % 32 == 5) begin
        n_checks++;
        if (digit_bcd !== 4'(frames)) begin
          n_fail++;
          $display("FAIL b2b_sequence frame%0d: got %h want %h", frames, digit_bcd, 4'(frames));
        end
      end
    end
    bus.in_valid = 1'b0;
    n_checks++;
    if (dut_xfer != 6 || frames != 6) begin
      n_fail++;
      $display("FAIL b2b_counts: transfers got %0d frames got %0d want 6 6", dut_xfer, frames);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_value = 16'h0000;
    test_reset();
    test_idle();
    test_accept();
    test_pending_full();
    test_bad_digit();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time got 200000 want finish earlier");
    $fatal(1, "watchdog expired");
  end

endmodule
